ahb_slave_interface: RTL and testbench

AHB-side front end of the AHB-to-APB bridge, sitting directly upstream of the APB controller. It checks whether each AHB address phase is a valid transfer, decodes the target APB slave, and pipelines address, write data and direction by two stages (Haddr1/Haddr2, Hwdata1/Hwdata2, Hwritereg). The APB controller consumes these registered copies. Optionally, the block generates the two-cycle AHB ERROR response for out-of-map addresses.

---
 rtl/ahb_bridge_pkg.sv | 39 +++
 rtl/ahb_slave_interface_if.sv | 40 ++++
 rtl/ahb_addr_decode.sv | 37 +++
 rtl/ahb_slave_interface.sv | 131 +++++++++++++
 tb/tb_ahb_slave_interface.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_bridge_pkg.sv
// ---------------------------------------------------------------------------
// ahb_bridge_pkg
// Shared definitions for the AHB side of the AHB-to-APB bridge:
//   - AHB HTRANS and HRESP encodings
//   - error-response FSM state encoding
//   - default APB slave base addresses and the 64 MB slave window size
//   - helper function that classifies a transfer as active (NONSEQ/SEQ)
// ---------------------------------------------------------------------------
package ahb_bridge_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [1:0] {
        ERR_OKAY = 2'b00,
        ERR_ERR1 = 2'b01,
        ERR_ERR2 = 2'b10
    } err_state_e;

    localparam logic [31:0] SLV0_BASE_DEF = 32'h8000_0000;
    localparam logic [31:0] SLV1_BASE_DEF = 32'h8400_0000;
    localparam logic [31:0] SLV2_BASE_DEF = 32'h8800_0000;
    localparam logic [31:0] SLV_WINDOW    = 32'h0400_0000;

    // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY do not.
    function automatic logic is_active(input logic [1:0] htrans);
        return htrans[1];
    endfunction

endpackage

// File: rtl/ahb_slave_interface_if.sv
// ---------------------------------------------------------------------------
// ahb_slave_interface_if
// Bundles the AHB-side request signals and the registered copies handed to
// the APB controller.
//   master modport : drives Haddr, Hwdata, Hwrite, Htrans, Hreadyin;
//                    observes valid, tempselx, pipeline copies, Hresp,
//                    Hready_err
//   slave modport  : the mirror image, used by ahb_slave_interface
// ---------------------------------------------------------------------------
interface ahb_slave_interface_if;

    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic        Hwrite;
    logic [1:0]  Htrans;
    logic        Hreadyin;

    logic        valid;
    logic [2:0]  tempselx;
    logic [31:0] Haddr1;
    logic [31:0] Haddr2;
    logic [31:0] Hwdata1;
    logic [31:0] Hwdata2;
    logic        Hwritereg;
    logic [1:0]  Hresp;
    logic        Hready_err;

    modport master (
        output Haddr, Hwdata, Hwrite, Htrans, Hreadyin,
        input  valid, tempselx, Haddr1, Haddr2, Hwdata1, Hwdata2,
               Hwritereg, Hresp, Hready_err
    );

    modport slave (
        input  Haddr, Hwdata, Hwrite, Htrans, Hreadyin,
        output valid, tempselx, Haddr1, Haddr2, Hwdata1, Hwdata2,
               Hwritereg, Hresp, Hready_err
    );

endinterface

// File: rtl/ahb_addr_decode.sv
// ---------------------------------------------------------------------------
// ahb_addr_decode
// Combinational address decoder for the three APB slave windows.
//   haddr    in   32  AHB address
//   in_map   out  1   address lies in [SLV0_BASE, SLV2_BASE + window)
//   tempselx out  3   one-hot slave select, 3'b000 when out of map
// ---------------------------------------------------------------------------
module ahb_addr_decode
    import ahb_bridge_pkg::*;
#(
    parameter logic [31:0] SLV0_BASE = SLV0_BASE_DEF,
    parameter logic [31:0] SLV1_BASE = SLV1_BASE_DEF,
    parameter logic [31:0] SLV2_BASE = SLV2_BASE_DEF
) (
    input  logic [31:0] haddr,
    output logic        in_map,
    output logic [2:0]  tempselx
);

    localparam logic [95:0] SLV_BASES = {SLV2_BASE, SLV1_BASE, SLV0_BASE};

    // Upper bound computed in 33 bits so a top window near 4 GB cannot wrap.
    localparam logic [32:0] MAP_END = {1'b0, SLV2_BASE} + {1'b0, SLV_WINDOW};

    assign in_map = (haddr >= SLV0_BASE) && ({1'b0, haddr} < MAP_END);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_slot
            localparam logic [31:0] BASE = SLV_BASES[gi*32 +: 32];
            // Gate with in_map so an address outside the map never selects.
            assign tempselx[gi] = in_map && (haddr >= BASE)
                                  && ((haddr - BASE) < SLV_WINDOW);
        end
    endgenerate

endmodule

// File: rtl/ahb_slave_interface.sv
// ---------------------------------------------------------------------------
// ahb_slave_interface
// AHB front end of the AHB-to-APB bridge. Qualifies each address phase,
// decodes the target APB slave and pipelines address, write data and
// direction by two accepted phases for the APB controller.
//
// Ports:
//   Hclk     in  bridge clock
//   Hresetn  in  asynchronous active-low reset
//   bus      ahb_slave_interface_if.slave
//            in : Haddr, Hwdata, Hwrite, Htrans, Hreadyin
//            out: valid, tempselx, Haddr1/2, Hwdata1/2, Hwritereg,
//                 Hresp, Hready_err
//
// Optional feature: define AHB_SLAVE_ERRRESP_EN to build the two-cycle AHB
// ERROR response for out-of-map transfers. Without it out-of-map transfers
// are dropped silently and the response is always OKAY.
// ---------------------------------------------------------------------------
module ahb_slave_interface
    import ahb_bridge_pkg::*;
#(
    parameter logic [31:0] SLV0_BASE = SLV0_BASE_DEF,
    parameter logic [31:0] SLV1_BASE = SLV1_BASE_DEF,
    parameter logic [31:0] SLV2_BASE = SLV2_BASE_DEF
) (
    input  logic                  Hclk,
    input  logic                  Hresetn,
    ahb_slave_interface_if.slave  bus
);

    logic        in_map;
    logic [2:0]  tempselx;
    logic        active;

    logic [31:0] haddr1_reg;
    logic [31:0] haddr2_reg;
    logic [31:0] hwdata1_reg;
    logic [31:0] hwdata2_reg;
    logic        hwrite_reg;

    ahb_addr_decode #(
        .SLV0_BASE (SLV0_BASE),
        .SLV1_BASE (SLV1_BASE),
        .SLV2_BASE (SLV2_BASE)
    ) u_decode (
        .haddr    (bus.Haddr),
        .in_map   (in_map),
        .tempselx (tempselx)
    );

    assign active = is_active(bus.Htrans);

    // Pipeline advances on every ready edge regardless of Htrans, so the
    // controller always sees the last two bus phases; wait states freeze it.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            haddr1_reg  <= '0;
            haddr2_reg  <= '0;
            hwdata1_reg <= '0;
            hwdata2_reg <= '0;
            hwrite_reg  <= 1'b0;
        end else if (bus.Hreadyin) begin
            haddr1_reg  <= bus.Haddr;
            haddr2_reg  <= haddr1_reg;
            hwdata1_reg <= bus.Hwdata;
            hwdata2_reg <= hwdata1_reg;
            hwrite_reg  <= bus.Hwrite;
        end
    end

`ifdef AHB_SLAVE_ERRRESP_EN
    err_state_e  state_reg;
    logic [1:0]  hresp_reg;
    logic        hready_err_reg;

    // Outputs are loaded together with the state so Hresp/Hready_err are
    // glitch-free registers reflecting the state being entered.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_reg      <= ERR_OKAY;
            hresp_reg      <= HRESP_OKAY;
            hready_err_reg <= 1'b1;
        end else begin
            case (state_reg)
                ERR_OKAY: begin
                    if (bus.Hreadyin && active && !in_map) begin
                        state_reg      <= ERR_ERR1;
                        hresp_reg      <= HRESP_ERROR;
                        hready_err_reg <= 1'b0;
                    end
                end
                // ERR1 and ERR2 advance unconditionally: Hready_err is what
                // stretches the bus, so Hreadyin must not stall the FSM.
                ERR_ERR1: begin
                    state_reg      <= ERR_ERR2;
                    hresp_reg      <= HRESP_ERROR;
                    hready_err_reg <= 1'b1;
                end
                ERR_ERR2: begin
                    state_reg      <= ERR_OKAY;
                    hresp_reg      <= HRESP_OKAY;
                    hready_err_reg <= 1'b1;
                end
                default: begin
                    state_reg      <= ERR_OKAY;
                    hresp_reg      <= HRESP_OKAY;
                    hready_err_reg <= 1'b1;
                end
            endcase
        end
    end

    // No transfer may be accepted while the first ERROR cycle is on the bus.
    assign bus.valid      = bus.Hreadyin && active && in_map
                            && (state_reg != ERR_ERR1);
    assign bus.Hresp      = hresp_reg;
    assign bus.Hready_err = hready_err_reg;
`else
    assign bus.valid      = bus.Hreadyin && active && in_map;
    assign bus.Hresp      = HRESP_OKAY;
    assign bus.Hready_err = 1'b1;
`endif

    assign bus.tempselx  = tempselx;
    assign bus.Haddr1    = haddr1_reg;
    assign bus.Haddr2    = haddr2_reg;
    assign bus.Hwdata1   = hwdata1_reg;
    assign bus.Hwdata2   = hwdata2_reg;
    assign bus.Hwritereg = hwrite_reg;

endmodule

// File: tb/tb_ahb_slave_interface.sv
// ---------------------------------------------------------------------------
// tb_ahb_slave_interface
// Directed scenarios followed by a randomized run checked against a
// behavioural model (accepted-phase history queues plus an error-window age
// counter). Honours AHB_SLAVE_ERRRESP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_ahb_slave_interface;

`ifdef AHB_SLAVE_ERRRESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ahb_slave_interface_if bus ();

    ahb_slave_interface dut (
        .Hclk    (clk),
        .Hresetn (rst_n),
        .bus     (bus)
    );

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_addr_q[$];
    logic [31:0] m_wdata_q[$];
    logic        m_write;
    int          m_err_age;   // 0: no error window, 1: first ERROR cycle, 2: second

    function automatic logic m_in_map(input logic [31:0] a);
        return (a >= 32'h8000_0000) && (a < 32'h8C00_0000);
    endfunction

    function automatic logic [2:0] m_sel(input logic [31:0] a);
        logic [31:0] idx;
        if (!m_in_map(a)) return 3'b000;
        idx = (a - 32'h8000_0000) / 32'h0400_0000;
        return 3'(3'b001 << idx);
    endfunction

    function automatic logic m_active(input logic [1:0] t);
        return (t == 2'b10) || (t == 2'b11);
    endfunction

    task automatic model_clear();
        m_addr_q.delete();
        m_wdata_q.delete();
        m_write   = 1'b0;
        m_err_age = 0;
    endtask

    // Called right after a rising edge with the inputs that were sampled.
    task automatic model_edge();
        if (bus.Hreadyin) begin
            m_addr_q.push_front(bus.Haddr);
            m_wdata_q.push_front(bus.Hwdata);
            m_write = bus.Hwrite;
            while (m_addr_q.size() > 2) void'(m_addr_q.pop_back());
            while (m_wdata_q.size() > 2) void'(m_wdata_q.pop_back());
        end
        if (ERR_EN) begin
            if (m_err_age == 1)      m_err_age = 2;
            else if (m_err_age == 2) m_err_age = 0;
            else if (bus.Hreadyin && m_active(bus.Htrans) && !m_in_map(bus.Haddr))
                m_err_age = 1;
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] w,
                         input logic wr, input logic [1:0] t, input logic rdy);
        bus.Haddr    = a;
        bus.Hwdata   = w;
        bus.Hwrite   = wr;
        bus.Htrans   = t;
        bus.Hreadyin = rdy;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive(32'h8000_0010, 32'h0, 1'b1, 2'b10, 1'b1);
        @(negedge clk); #1;
        checks++; if (bus.Haddr1 !== 32'h0 || bus.Haddr2 !== 32'h0) begin
            errors++; $display("FAIL reset_haddr: got %h/%h expected 0/0", bus.Haddr1, bus.Haddr2); end
        checks++; if (bus.Hwdata1 !== 32'h0 || bus.Hwdata2 !== 32'h0 || bus.Hwritereg !== 1'b0) begin
            errors++; $display("FAIL reset_wdata: got %h/%h/%b expected 0/0/0", bus.Hwdata1, bus.Hwdata2, bus.Hwritereg); end
        checks++; if (bus.Hresp !== 2'b00 || bus.Hready_err !== 1'b1) begin
            errors++; $display("FAIL reset_resp: got %b/%b expected 00/1", bus.Hresp, bus.Hready_err); end
        checks++; if (bus.valid !== 1'b1 || bus.tempselx !== 3'b001) begin
            errors++; $display("FAIL reset_comb: got %b/%b expected 1/001", bus.valid, bus.tempselx); end
        $display("reset: Haddr1=%h Hresp=%b valid=%b", bus.Haddr1, bus.Hresp, bus.valid);
    endtask

    task automatic test_write();
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h8000_0010, 32'h0, 1'b1, 2'b10, 1'b1);
        #1;
        checks++; if (bus.valid !== 1'b1 || bus.tempselx !== 3'b001) begin
            errors++; $display("FAIL write_decode: got %b/%b expected 1/001", bus.valid, bus.tempselx); end
        @(posedge clk); #1;
        checks++; if (bus.Haddr1 !== 32'h8000_0010 || bus.Hwritereg !== 1'b1) begin
            errors++; $display("FAIL write_addr1: got %h/%b expected 80000010/1", bus.Haddr1, bus.Hwritereg); end
        @(negedge clk);
        drive(32'h0, 32'hDEAD_BEEF, 1'b0, 2'b00, 1'b1);
        @(posedge clk); #1;
        checks++; if (bus.Hwdata1 !== 32'hDEAD_BEEF || bus.Haddr2 !== 32'h8000_0010) begin
            errors++; $display("FAIL write_data: got %h/%h expected deadbeef/80000010", bus.Hwdata1, bus.Haddr2); end
        $display("write: Haddr2=%h Hwdata1=%h", bus.Haddr2, bus.Hwdata1);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive(32'h8400_0000, 32'h0, 1'b0, 2'b10, 1'b1); #1;
        checks++; if (bus.tempselx !== 3'b010 || bus.valid !== 1'b1) begin
            errors++; $display("FAIL b2b_sel1: got %b/%b expected 010/1", bus.tempselx, bus.valid); end
        @(negedge clk);
        drive(32'h8800_0004, 32'h0, 1'b0, 2'b10, 1'b1); #1;
        checks++; if (bus.tempselx !== 3'b100 || bus.valid !== 1'b1) begin
            errors++; $display("FAIL b2b_sel2: got %b/%b expected 100/1", bus.tempselx, bus.valid); end
        @(posedge clk); #1;
        checks++; if (bus.Haddr2 !== 32'h8400_0000 || bus.Haddr1 !== 32'h8800_0004 || bus.Hwritereg !== 1'b0) begin
            errors++; $display("FAIL b2b_pipe: got %h/%h/%b expected 84000000/88000004/0", bus.Haddr2, bus.Haddr1, bus.Hwritereg); end
        $display("back_to_back: Haddr1=%h Haddr2=%h", bus.Haddr1, bus.Haddr2);
    endtask

    task automatic test_wait_state();
        @(negedge clk); drive(32'h8000_0020, 32'hA5A5_0001, 1'b1, 2'b10, 1'b1);
        @(negedge clk); drive(32'h8000_0024, 32'hA5A5_0002, 1'b1, 2'b11, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(32'h8000_0100, 32'hFFFF_FFFF, 1'b0, 2'b10, 1'b0); #1;
            checks++; if (bus.valid !== 1'b0) begin
                errors++; $display("FAIL wait_valid%0d: got %b expected 0", i, bus.valid); end
            @(posedge clk); #1;
            checks++; if (bus.Haddr1 !== 32'h8000_0024 || bus.Haddr2 !== 32'h8000_0020) begin
                errors++; $display("FAIL wait_addr%0d: got %h/%h expected 80000024/80000020", i, bus.Haddr1, bus.Haddr2); end
            checks++; if (bus.Hwdata1 !== 32'hA5A5_0002 || bus.Hwdata2 !== 32'hA5A5_0001 || bus.Hwritereg !== 1'b1) begin
                errors++; $display("FAIL wait_data%0d: got %h/%h/%b expected a5a50002/a5a50001/1", i, bus.Hwdata1, bus.Hwdata2, bus.Hwritereg); end
            $display("wait %0d: Haddr1=%h Hwdata1=%h", i, bus.Haddr1, bus.Hwdata1);
        end
    endtask

    task automatic test_idle_busy();
        @(negedge clk); drive(32'h8000_0000, 32'h0, 1'b0, 2'b00, 1'b1); #1;
        checks++; if (bus.valid !== 1'b0) begin
            errors++; $display("FAIL idle_valid: got %b expected 0", bus.valid); end
        @(negedge clk); drive(32'h8000_0004, 32'h0, 1'b0, 2'b01, 1'b1); #1;
        checks++; if (bus.valid !== 1'b0) begin
            errors++; $display("FAIL busy_valid: got %b expected 0", bus.valid); end
        @(posedge clk); #1;
        checks++; if (bus.Haddr1 !== 32'h8000_0004 || bus.Haddr2 !== 32'h8000_0000) begin
            errors++; $display("FAIL idle_busy_pipe: got %h/%h expected 80000004/80000000", bus.Haddr1, bus.Haddr2); end
        $display("idle_busy: Haddr1=%h Haddr2=%h", bus.Haddr1, bus.Haddr2);
    endtask

    task automatic test_error();
        @(negedge clk); drive(32'h9000_0000, 32'h0, 1'b1, 2'b10, 1'b1); #1;
        checks++; if (bus.valid !== 1'b0 || bus.tempselx !== 3'b000) begin
            errors++; $display("FAIL err_decode: got %b/%b expected 0/000", bus.valid, bus.tempselx); end
        @(posedge clk); #1;
        checks++; if (bus.Hresp !== (ERR_EN ? 2'b01 : 2'b00) || bus.Hready_err !== !ERR_EN) begin
            errors++; $display("FAIL err_cycle1: got %b/%b expected %b/%b", bus.Hresp, bus.Hready_err, ERR_EN ? 2'b01 : 2'b00, !ERR_EN); end
        // An in-map transfer offered during the first ERROR cycle is refused.
        @(negedge clk); drive(32'h8000_0040, 32'h0, 1'b0, 2'b10, 1'b1); #1;
        checks++; if (bus.valid !== !ERR_EN) begin
            errors++; $display("FAIL err1_valid: got %b expected %b", bus.valid, !ERR_EN); end
        @(posedge clk); #1;
        checks++; if (bus.Hresp !== (ERR_EN ? 2'b01 : 2'b00) || bus.Hready_err !== 1'b1) begin
            errors++; $display("FAIL err_cycle2: got %b/%b expected %b/1", bus.Hresp, bus.Hready_err, ERR_EN ? 2'b01 : 2'b00); end
        @(negedge clk); drive(32'h0, 32'h0, 1'b0, 2'b00, 1'b1);
        @(posedge clk); #1;
        checks++; if (bus.Hresp !== 2'b00 || bus.Hready_err !== 1'b1) begin
            errors++; $display("FAIL err_done: got %b/%b expected 00/1", bus.Hresp, bus.Hready_err); end
        $display("error: final Hresp=%b Hready_err=%b", bus.Hresp, bus.Hready_err);
    endtask

    task automatic test_reset_in_err1();
        @(negedge clk); drive(32'h9000_0000, 32'h1234_5678, 1'b1, 2'b10, 1'b1);
        @(posedge clk); #1;
        checks++; if (bus.Hready_err !== !ERR_EN) begin
            errors++; $display("FAIL rst_err1_pre: got %b expected %b", bus.Hready_err, !ERR_EN); end
        rst_n = 1'b0; #1;
        checks++; if (bus.Hresp !== 2'b00 || bus.Hready_err !== 1'b1) begin
            errors++; $display("FAIL rst_err1_resp: got %b/%b expected 00/1", bus.Hresp, bus.Hready_err); end
        checks++; if ({bus.Haddr1, bus.Haddr2, bus.Hwdata1, bus.Hwdata2, bus.Hwritereg} !== '0) begin
            errors++; $display("FAIL rst_err1_pipe: got %h/%h/%h/%h/%b expected zeros", bus.Haddr1, bus.Haddr2, bus.Hwdata1, bus.Hwdata2, bus.Hwritereg); end
        $display("reset_in_err1: Hresp=%b Haddr1=%h", bus.Hresp, bus.Haddr1);
        @(negedge clk); drive(32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
        rst_n = 1'b1;
    endtask

    // ---------------- randomized run against the model ----------------
    task automatic test_random();
        logic [31:0] edges[6];
        logic [31:0] a;
        logic        exp_valid;
        edges = '{32'h7FFF_FFFC, 32'h8000_0000, 32'h83FF_FFFC,
                  32'h8BFF_FFFC, 32'h8C00_0000, 32'hFFFF_FFFC};
        @(negedge clk); rst_n = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        model_clear();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            case ($urandom_range(0, 3))
                0:       a = edges[$urandom_range(0, 5)];
                1:       a = $urandom;
                default: a = 32'h8000_0000 + ($urandom % 32'h0C00_0000);
            endcase
            drive(a, $urandom, 1'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0));
            #1;
            exp_valid = bus.Hreadyin && m_active(bus.Htrans) && m_in_map(a) && (m_err_age != 1);
            checks++; if (bus.valid !== exp_valid || bus.tempselx !== m_sel(a)) begin
                errors++; $display("FAIL rnd_comb[%0d]: got %b/%b expected %b/%b addr %h", n, bus.valid, bus.tempselx, exp_valid, m_sel(a), a); end
            @(posedge clk);
            model_edge();
            #1;
            checks++; if (bus.Haddr1 !== (m_addr_q.size() > 0 ? m_addr_q[0] : 32'h0) ||
                          bus.Haddr2 !== (m_addr_q.size() > 1 ? m_addr_q[1] : 32'h0)) begin
                errors++; $display("FAIL rnd_addr[%0d]: got %h/%h", n, bus.Haddr1, bus.Haddr2); end
            checks++; if (bus.Hwdata1 !== (m_wdata_q.size() > 0 ? m_wdata_q[0] : 32'h0) ||
                          bus.Hwdata2 !== (m_wdata_q.size() > 1 ? m_wdata_q[1] : 32'h0) ||
                          bus.Hwritereg !== m_write) begin
                errors++; $display("FAIL rnd_data[%0d]: got %h/%h/%b expected write %b", n, bus.Hwdata1, bus.Hwdata2, bus.Hwritereg, m_write); end
            checks++; if (bus.Hresp !== (m_err_age != 0 ? 2'b01 : 2'b00) || bus.Hready_err !== (m_err_age != 1)) begin
                errors++; $display("FAIL rnd_resp[%0d]: got %b/%b expected age %0d", n, bus.Hresp, bus.Hready_err, m_err_age); end
            $display("rnd %0d: addr=%h trans=%b rdy=%b valid=%b sel=%b resp=%b", n, a, bus.Htrans, bus.Hreadyin, exp_valid, bus.tempselx, bus.Hresp);
        end
    endtask

    initial begin
        drive(32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
        test_reset();
        test_write();
        test_back_to_back();
        test_wait_state();
        test_idle_busy();
        test_error();
        test_reset_in_err1();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
